qft_pair_sequencer: RTL and testbench



---
 rtl/qft_pair_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_qft_pair_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qft_pair_sequencer.sv
// qft_pair_sequencer
// Pair-issue stage in front of the QFT butterfly units. A start request walks
// every amplitude pair (i, i | 1<<target) of the state vector. It reads both
// amplitudes from the state memory and presents them, with the constant 1/sqrt(2)
// scale, on a valid/ready stream.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, target         one-cycle request and target qubit (sampled with start)
//   busy, done, err       run in progress, end-of-run pulse, illegal-target pulse
//   rd_en, rd_addr0/1     memory read strobe and pair addresses
//   rd_data{0,1}_{re,im}  read data, valid exactly one cycle after rd_en
//   out_valid, out_ready  output stream handshake
//   out_idx0/1            pair indices for writeback
//   out_a_*, out_b_*      amplitudes at idx0 / idx1 (butterfly in1 / in2)
//   out_scale             constant scale_val (butterfly in3)
module qft_pair_sequencer #(
  parameter int num_qubit      = 4,
  parameter int complexnum_bit = 24,
  parameter int fp_bit         = 22,
  parameter int scale_val      = 2965821,
  localparam int TW = (num_qubit > 1) ? $clog2(num_qubit) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [TW-1:0]             target,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      rd_en,
  output logic [num_qubit-1:0]      rd_addr0,
  output logic [num_qubit-1:0]      rd_addr1,
  input  logic [complexnum_bit-1:0] rd_data0_re,
  input  logic [complexnum_bit-1:0] rd_data0_im,
  input  logic [complexnum_bit-1:0] rd_data1_re,
  input  logic [complexnum_bit-1:0] rd_data1_im,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [num_qubit-1:0]      out_idx0,
  output logic [num_qubit-1:0]      out_idx1,
  output logic [complexnum_bit-1:0] out_a_re,
  output logic [complexnum_bit-1:0] out_a_im,
  output logic [complexnum_bit-1:0] out_b_re,
  output logic [complexnum_bit-1:0] out_b_im,
  output logic [complexnum_bit:0]   out_scale
);

  localparam int NPAIR = 1 << (num_qubit - 1);
  localparam logic [num_qubit-1:0] P_LAST = num_qubit'(NPAIR - 1);
  localparam logic [TW:0] TGT_LIMIT = (TW + 1)'(num_qubit);
  localparam int EW = 2 * num_qubit + 4 * complexnum_bit;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 done_nxt;
  logic                 err_nxt;
  logic [TW-1:0]        tgt;
  logic [num_qubit-1:0] p;
  logic                 pop;
  logic                 start_ok;
  logic                 last_issue;
  logic [1:0]           occ;
  logic [1:0]           occ_nxt;
  logic [num_qubit-1:0] addr0;
  logic [num_qubit-1:0] addr1;

  logic                 vld_p1;
  logic [num_qubit-1:0] idx0_p1;
  logic [num_qubit-1:0] idx1_p1;

  logic [EW-1:0]        fifo_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           cnt;

  // fp_bit describes the amplitude format only; data passes through unscaled.
  logic [31:0]          unused_fp;
  assign unused_fp = 32'(fp_bit);

  // Pair counter p with a zero bit inserted at position pos.
  function automatic logic [num_qubit-1:0] insert_zero(
    input logic [num_qubit-1:0] pv,
    input logic [TW-1:0]        pos
  );
    logic [num_qubit-1:0] lo;
    lo = (num_qubit'(1) << pos) - num_qubit'(1);
    return ((pv & ~lo) << 1) | (pv & lo);
  endfunction

  assign out_valid  = (cnt != 2'd0);
  assign pop        = out_valid & out_ready;
  // Credits: buffered entries plus the read still in flight.
  assign occ        = cnt + {1'b0, vld_p1};
  assign start_ok   = ({1'b0, target} < TGT_LIMIT);
  // A pop this cycle frees a slot for the data of a read issued now.
  assign rd_en      = (state == S_RUN) && ((occ < 2'd2) || pop);
  assign last_issue = rd_en && (p == P_LAST);
  assign occ_nxt    = occ + {1'b0, rd_en} - {1'b0, pop};

  assign addr0    = insert_zero(p, tgt);
  assign addr1    = addr0 | (num_qubit'(1) << tgt);
  assign rd_addr0 = rd_en ? addr0 : '0;
  assign rd_addr1 = rd_en ? addr1 : '0;

  assign busy      = (state != S_IDLE);
  assign out_scale = (complexnum_bit + 1)'(scale_val);

  assign {out_idx0, out_idx1, out_a_re, out_a_im, out_b_re, out_b_im} = fifo_mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (start_ok) state_nxt = S_RUN;
          else          err_nxt   = 1'b1;
        end
      end
      S_RUN: begin
        if (last_issue) begin
          if (occ_nxt == 2'd0) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (occ_nxt == 2'd0) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p   <= '0;
      tgt <= '0;
    end else if ((state == S_IDLE) && start && start_ok) begin
      p   <= '0;
      tgt <= target;
    end else if (rd_en) begin
      p <= p + num_qubit'(1);
    end
  end

  // Stage p1: read issued, memory returns data next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      idx0_p1 <= '0;
      idx1_p1 <= '0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) begin
        idx0_p1 <= addr0;
        idx1_p1 <= addr1;
      end
    end
  end

  // Stage p2: returning data always lands in the buffer; credits guarantee room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (vld_p1) begin
        fifo_mem[wr_ptr] <= {idx0_p1, idx1_p1, rd_data0_re, rd_data0_im, rd_data1_re, rd_data1_im};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, vld_p1} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_qft_pair_sequencer.sv
module tb_qft_pair_sequencer;
  localparam int NQ = 4;
  localparam int CB = 24;
  localparam int SC = 2965821;
  localparam int NP = 8;
  localparam int NN = 16;

  typedef struct packed {
    logic [NQ-1:0] i0;
    logic [NQ-1:0] i1;
    logic [CB-1:0] are;
    logic [CB-1:0] aim;
    logic [CB-1:0] bre;
    logic [CB-1:0] bim;
  } pair_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, busy, done, err, rd_en, out_valid, out_ready;
  logic [1:0]    target;
  logic [NQ-1:0] rd_addr0, rd_addr1, out_idx0, out_idx1;
  logic [CB-1:0] rd_data0_re, rd_data0_im, rd_data1_re, rd_data1_im;
  logic [CB-1:0] out_a_re, out_a_im, out_b_re, out_b_im;
  logic [CB:0]   out_scale;

  logic          n5_start, n5_busy, n5_done, n5_err, n5_rd_en, n5_out_valid;
  logic          n5_out_ready = 1'b1;
  logic [2:0]    n5_target;
  logic [4:0]    n5_rd_addr0, n5_rd_addr1, n5_out_idx0, n5_out_idx1;
  logic [CB-1:0] n5_zero = '0;
  logic [CB-1:0] n5_a_re, n5_a_im, n5_b_re, n5_b_im;
  logic [CB:0]   n5_scale;

  qft_pair_sequencer #(.num_qubit(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0_re(rd_data0_re), .rd_data0_im(rd_data0_im),
    .rd_data1_re(rd_data1_re), .rd_data1_im(rd_data1_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx0(out_idx0), .out_idx1(out_idx1),
    .out_a_re(out_a_re), .out_a_im(out_a_im), .out_b_re(out_b_re), .out_b_im(out_b_im),
    .out_scale(out_scale)
  );

  qft_pair_sequencer #(.num_qubit(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(n5_start), .target(n5_target),
    .busy(n5_busy), .done(n5_done), .err(n5_err),
    .rd_en(n5_rd_en), .rd_addr0(n5_rd_addr0), .rd_addr1(n5_rd_addr1),
    .rd_data0_re(n5_zero), .rd_data0_im(n5_zero),
    .rd_data1_re(n5_zero), .rd_data1_im(n5_zero),
    .out_valid(n5_out_valid), .out_ready(n5_out_ready),
    .out_idx0(n5_out_idx0), .out_idx1(n5_out_idx1),
    .out_a_re(n5_a_re), .out_a_im(n5_a_im), .out_b_re(n5_b_re), .out_b_im(n5_b_im),
    .out_scale(n5_scale)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run_pops = 0;
  int run_issued = 0;
  int first_rd = -1;
  int first_valid = -1;
  int done_cyc = -1;
  int done_cnt = 0;
  int err_cnt = 0;
  int ready_mode = 0;
  pair_t exp_q[$];
  logic [CB-1:0] mem_re [NN];
  logic [CB-1:0] mem_im [NN];

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every index with bit t clear pairs with index + 2^t, in ascending order.
  task automatic push_expected(input int t);
    pair_t e;
    for (int i = 0; i < NN; i++) begin
      if (((i >> t) & 1) == 0) begin
        e.i0  = NQ'(i);
        e.i1  = NQ'(i + (1 << t));
        e.are = mem_re[i];
        e.aim = mem_im[i];
        e.bre = mem_re[i + (1 << t)];
        e.bim = mem_im[i + (1 << t)];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < NN; k++) begin
      mem_re[k] = CB'($urandom);
      mem_im[k] = CB'($urandom);
    end
  endtask

  task automatic check_quiet_outputs(input string tag);
    chk(busy == 1'b0,      {tag, "_busy"},      longint'(busy), 0);
    chk(done == 1'b0,      {tag, "_done"},      longint'(done), 0);
    chk(err == 1'b0,       {tag, "_err"},       longint'(err), 0);
    chk(rd_en == 1'b0,     {tag, "_rd_en"},     longint'(rd_en), 0);
    chk(out_valid == 1'b0, {tag, "_out_valid"}, longint'(out_valid), 0);
    chk(rd_addr0 == '0 && rd_addr1 == '0, {tag, "_rd_addr"}, longint'({rd_addr0, rd_addr1}), 0);
    chk(out_idx0 == '0 && out_idx1 == '0, {tag, "_out_idx"}, longint'({out_idx0, out_idx1}), 0);
    chk({out_a_re, out_a_im, out_b_re, out_b_im} == '0, {tag, "_out_data"}, longint'(out_a_re), 0);
    chk(out_scale == (CB + 1)'(SC), {tag, "_scale"}, longint'(out_scale), SC);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // State memory: registered read, garbage on the bus when not reading.
  initial begin
    logic          en;
    logic [NQ-1:0] a0, a1;
    rd_data0_re = '0; rd_data0_im = '0; rd_data1_re = '0; rd_data1_im = '0;
    forever begin
      @(negedge clk);
      en = rd_en; a0 = rd_addr0; a1 = rd_addr1;
      @(posedge clk);
      #1;
      if (en) begin
        rd_data0_re = mem_re[a0]; rd_data0_im = mem_im[a0];
        rd_data1_re = mem_re[a1]; rd_data1_im = mem_im[a1];
      end else begin
        rd_data0_re = CB'($urandom); rd_data0_im = CB'($urandom);
        rd_data1_re = CB'($urandom); rd_data1_im = CB'($urandom);
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard on every handshake.
  initial begin
    pair_t e, cur, held;
    bit stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        cur = {out_idx0, out_idx1, out_a_re, out_a_im, out_b_re, out_b_im};
        if (stall_prev) begin
          chk(out_valid == 1'b1, "valid_held", longint'(out_valid), 1);
          chk(cur == held, "stall_stable", longint'(cur.i0), longint'(held.i0));
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_pop", longint'(cur.i0), -1);
          end else begin
            e = exp_q.pop_front();
            chk(cur.i0 == e.i0, "idx0", longint'(cur.i0), longint'(e.i0));
            chk(cur.i1 == e.i1, "idx1", longint'(cur.i1), longint'(e.i1));
            chk(cur.are == e.are, "a_re", longint'($signed(cur.are)), longint'($signed(e.are)));
            chk(cur.aim == e.aim, "a_im", longint'($signed(cur.aim)), longint'($signed(e.aim)));
            chk(cur.bre == e.bre, "b_re", longint'($signed(cur.bre)), longint'($signed(e.bre)));
            chk(cur.bim == e.bim, "b_im", longint'($signed(cur.bim)), longint'($signed(e.bim)));
            chk(out_scale == (CB + 1)'(SC), "scale", longint'(out_scale), SC);
          end
          run_pops++;
        end
        if (out_valid && !out_ready) begin
          stall_prev = 1'b1;
          held = cur;
        end else begin
          stall_prev = 1'b0;
        end
        if (rd_en) begin
          run_issued++;
          if (first_rd < 0) first_rd = cyc;
          chk((run_issued - run_pops) <= 2, "occupancy", run_issued - run_pops, 2);
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk(run_pops == NP, "done_after_last_pop", run_pops, NP);
          chk(exp_q.size() == 0, "done_queue_empty", exp_q.size(), 0);
          chk(busy == 1'b0, "busy_low_at_done", longint'(busy), 0);
        end
        if (err) err_cnt++;
      end
    end
  end

  task automatic run_seq(input int t, input bit timing, input bit restart);
    int s, dc0, ec0;
    bit got;
    run_pops = 0; run_issued = 0; first_rd = -1; first_valid = -1; done_cyc = -1;
    dc0 = done_cnt; ec0 = err_cnt;
    @(posedge clk);
    #1;
    start = 1'b1; target = 2'(t); s = cyc;
    push_expected(t);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk(busy == 1'b1, "busy_after_start", longint'(busy), 1);
    chk(rd_en == 1'b1, "first_rd_en", longint'(rd_en), 1);
    if (restart) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; target = 2'((t + 1) % 4);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    #1;
    chk(got, "done_seen", longint'(got), 1);
    if (timing) begin
      chk(first_rd == s + 1, "rd_latency", first_rd - s, 1);
      chk(first_valid == s + 3, "valid_latency", first_valid - s, 3);
      chk(done_cyc == s + 11, "done_cycle", done_cyc - s, 11);
    end
    repeat (3) @(negedge clk);
    #1;
    chk(done_cnt == dc0 + 1, "single_done", done_cnt - dc0, 1);
    chk(err_cnt == ec0, "no_err", err_cnt - ec0, 0);
    chk(exp_q.size() == 0, "all_pairs_seen", exp_q.size(), 0);
    chk(run_pops == NP, "pop_count", run_pops, NP);
  endtask

  initial begin
    int dc0, n5_pops;
    bit got;
    rst_n = 1'b0; start = 1'b0; target = '0;
    n5_start = 1'b0; n5_target = '0;
    for (int k = 0; k < NN; k++) begin mem_re[k] = '0; mem_im[k] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet_outputs("reset");
    chk(n5_busy == 1'b0 && n5_err == 1'b0, "n5_reset", longint'({n5_busy, n5_err}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // memory[k] = k / -k, target 0, ready held high
    for (int k = 0; k < NN; k++) begin
      mem_re[k] = CB'(k);
      mem_im[k] = CB'(-k);
    end
    ready_mode = 0;
    run_seq(0, 1'b1, 1'b0);

    fill_random();
    run_seq(3, 1'b1, 1'b0);

    fill_random();
    ready_mode = 1;
    run_seq(2, 1'b0, 1'b0);

    fill_random();
    run_seq(1, 1'b0, 1'b1);

    // reset after three pops, then a fresh run on target 1
    ready_mode = 0;
    fill_random();
    run_pops = 0; run_issued = 0;
    @(posedge clk);
    #1;
    start = 1'b1; target = 2'd2;
    push_expected(2);
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      #1;
      if (run_pops >= 3) got = 1'b1;
    end
    chk(got, "three_pops_seen", run_pops, 3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    dc0 = done_cnt;
    @(negedge clk);
    check_quiet_outputs("midrun_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk(done_cnt == dc0, "no_done_after_reset", done_cnt - dc0, 0);
    chk(busy == 1'b0, "idle_after_reset", longint'(busy), 0);
    fill_random();
    run_seq(1, 1'b1, 1'b0);

    // num_qubit=5: target 6 is illegal
    @(posedge clk);
    #1;
    n5_start = 1'b1; n5_target = 3'd6;
    @(posedge clk);
    #1;
    n5_start = 1'b0;
    @(negedge clk);
    chk(n5_err == 1'b1, "n5_err_pulse", longint'(n5_err), 1);
    chk(n5_busy == 1'b0, "n5_busy_illegal", longint'(n5_busy), 0);
    chk(n5_rd_en == 1'b0, "n5_rd_en_illegal", longint'(n5_rd_en), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(n5_err == 1'b0, "n5_err_width", longint'(n5_err), 0);
      chk(n5_busy == 1'b0 && n5_rd_en == 1'b0, "n5_stays_idle", longint'({n5_busy, n5_rd_en}), 0);
    end

    // num_qubit=5: highest legal target
    @(posedge clk);
    #1;
    n5_start = 1'b1; n5_target = 3'd4;
    @(posedge clk);
    #1;
    n5_start = 1'b0;
    @(negedge clk);
    chk(n5_busy == 1'b1 && n5_err == 1'b0, "n5_legal_start", longint'({n5_busy, n5_err}), 2);
    n5_pops = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (n5_out_valid && n5_out_ready) begin
        if (n5_pops == 0)
          chk(n5_out_idx0 == 5'd0 && n5_out_idx1 == 5'd16, "n5_first_pair",
              longint'({n5_out_idx0, n5_out_idx1}), 16);
        n5_pops++;
      end
      if (n5_done) got = 1'b1;
      else @(negedge clk);
    end
    chk(got, "n5_done_seen", longint'(got), 1);
    chk(n5_pops == 16, "n5_pop_count", n5_pops, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
